// File: rtl/jtag_tap_master.sv
// Command-driven JTAG TAP sequencer: expands TLR / SHIFT_IR / SHIFT_DR / IDLE
// commands into registered TMS/TDI sequences and returns the captured TDO bits.
module jtag_tap_master #(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7
) (
  input  logic               tck,
  input  logic               trst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic               tms_o,
  output logic               tdi_o,
  input  logic               tdo_i,
  output logic               busy
);

  localparam int CNT_W = LEN_W + 1;
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [1:0] OP_TLR  = 2'b00;
  localparam logic [1:0] OP_IR   = 2'b01;
  localparam logic [1:0] OP_DR   = 2'b10;
  localparam logic [1:0] OP_IDLE = 2'b11;

  typedef enum logic [2:0] {
    S_RESET,
    S_INIT_TLR,
    S_IDLE,
    S_RUN,
    S_RESP
  } state_t;

  state_t             state;
  logic [1:0]         op_q;
  logic               err_q;
  logic [CNT_W-1:0]   len_q;
  logic [MAX_LEN-1:0] data_q;
  logic [CNT_W-1:0]   cnt;

  logic [CNT_W-1:0] len_in;
  logic             reject;
  logic [CNT_W-1:0] pre;
  logic [CNT_W-1:0] shift_end;
  logic [CNT_W-1:0] total;
  logic [CNT_W-1:0] prev;
  logic [IDX_W-1:0] tdi_idx;
  logic [IDX_W-1:0] cap_idx;
  logic             is_shift;
  logic             cur_shift;
  logic             prev_shift;
  logic             seq_tms;
  logic             seq_tdi;

  assign len_in = {1'b0, cmd_len};
  assign reject = ((cmd_op == OP_IR) || (cmd_op == OP_DR)) &&
                  ((len_in == '0) || (len_in > CNT_W'(MAX_LEN)));

  // cnt is the index of the sequence value registered on the current edge;
  // prev is the index whose TDI bit the TAP is shifting right now.
  always_comb begin
    is_shift   = ((op_q == OP_IR) || (op_q == OP_DR)) && !err_q;
    pre        = (op_q == OP_IR) ? CNT_W'(4) : CNT_W'(3);
    shift_end  = pre + len_q;
    prev       = cnt - CNT_W'(1);
    tdi_idx    = IDX_W'(cnt - pre);
    cap_idx    = IDX_W'(prev - pre);
    cur_shift  = is_shift && (cnt >= pre) && (cnt < shift_end);
    prev_shift = is_shift && (prev >= pre) && (prev < shift_end);
    total      = CNT_W'(1);
    seq_tms    = 1'b0;
    seq_tdi    = 1'b1;
    if (!err_q) begin
      case (op_q)
        OP_TLR: begin
          total   = CNT_W'(6);
          seq_tms = (cnt < CNT_W'(5));
        end
        OP_IR, OP_DR: begin
          total = shift_end + CNT_W'(2);
          if (cnt < pre) begin
            seq_tms = (op_q == OP_IR) ? (cnt < CNT_W'(2)) : (cnt == '0);
          end else if (cur_shift) begin
            seq_tms = (cnt == shift_end - CNT_W'(1));
            seq_tdi = data_q[tdi_idx];
          end else begin
            seq_tms = (cnt == shift_end);
          end
        end
        default: begin
          total = (len_q == '0) ? CNT_W'(1) : len_q;
        end
      endcase
    end
  end

  // Main sequencer: reset, automatic TLR, command acceptance, run, response.
  always_ff @(posedge tck) begin
    if (trst) begin
      state     <= S_RESET;
      tms_o     <= 1'b1;
      tdi_o     <= 1'b1;
      busy      <= 1'b1;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      op_q      <= OP_TLR;
      err_q     <= 1'b0;
      len_q     <= '0;
      data_q    <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        S_RESET: begin
          tms_o <= 1'b1;
          tdi_o <= 1'b1;
          cnt   <= CNT_W'(1);
          state <= S_INIT_TLR;
        end
        S_INIT_TLR: begin
          if (cnt == total) begin
            tms_o     <= 1'b0;
            tdi_o     <= 1'b1;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end else begin
            tms_o <= seq_tms;
            tdi_o <= seq_tdi;
            cnt   <= cnt + CNT_W'(1);
          end
        end
        S_IDLE: begin
          tms_o <= 1'b0;
          tdi_o <= 1'b1;
          if (cmd_valid) begin
            op_q      <= cmd_op;
            len_q     <= len_in;
            data_q    <= cmd_data;
            err_q     <= reject;
            cnt       <= CNT_W'(1);
            tms_o     <= (cmd_op != OP_IDLE) && !reject;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (prev_shift) begin
            rsp_data[cap_idx] <= tdo_i;
          end
          if (cnt == total) begin
            tms_o     <= 1'b0;
            tdi_o     <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= err_q;
            state     <= S_RESP;
          end else begin
            tms_o <= seq_tms;
            tdi_o <= seq_tdi;
            cnt   <= cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_tap_master.sv
// Bench for jtag_tap_master: a behavioural TAP (IR capture 00001, DR loopback)
// drives tdo_i; expected responses go through a scoreboard queue.
module tb_jtag_tap_master;

  localparam logic [1:0] OP_TLR  = 2'b00;
  localparam logic [1:0] OP_IR   = 2'b01;
  localparam logic [1:0] OP_DR   = 2'b10;
  localparam logic [1:0] OP_IDLE = 2'b11;

  logic        tck = 1'b0;
  logic        trst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        rsp_ready = 1'b1;
  logic [1:0]  cmd_op = 2'b00;
  logic [6:0]  cmd_len = 7'd0;
  logic [63:0] cmd_data = 64'd0;
  logic        cmd_ready, rsp_valid, rsp_err, tms_o, tdi_o, busy, tdo_i;
  logic [63:0] rsp_data;

  jtag_tap_master #(.MAX_LEN(64), .LEN_W(7)) dut (
    .tck(tck), .trst(trst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .tms_o(tms_o), .tdi_o(tdi_o), .tdo_i(tdo_i), .busy(busy)
  );

  always #5 tck = ~tck;

  typedef enum logic [3:0] {
    TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUDR, EX2DR, UPDDR,
    SELIR, CAPIR, SHIR, EX1IR, PAUIR, EX2IR, UPDIR
  } tap_t;

  tap_t       tap_state = TLR;
  logic [4:0] ir_sr = 5'b0;

  function automatic tap_t tap_next(input tap_t s, input logic t);
    case (s)
      TLR:     return t ? TLR   : RTI;
      RTI:     return t ? SELDR : RTI;
      SELDR:   return t ? SELIR : CAPDR;
      CAPDR:   return t ? EX1DR : SHDR;
      SHDR:    return t ? EX1DR : SHDR;
      EX1DR:   return t ? UPDDR : PAUDR;
      PAUDR:   return t ? EX2DR : PAUDR;
      EX2DR:   return t ? UPDDR : SHDR;
      UPDDR:   return t ? SELDR : RTI;
      SELIR:   return t ? TLR   : CAPIR;
      CAPIR:   return t ? EX1IR : SHIR;
      SHIR:    return t ? EX1IR : SHIR;
      EX1IR:   return t ? UPDIR : PAUIR;
      PAUIR:   return t ? EX2IR : PAUIR;
      EX2IR:   return t ? UPDIR : SHIR;
      UPDIR:   return t ? SELDR : RTI;
      default: return TLR;
    endcase
  endfunction

  // Behavioural TAP: IR captures 00001, DR shifts TDI straight back to TDO.
  always @(posedge tck) begin
    if (tap_state == CAPIR) ir_sr <= 5'b00001;
    else if (tap_state == SHIR) ir_sr <= {tdi_o, ir_sr[4:1]};
    tap_state <= tap_next(tap_state, tms_o);
  end

  assign tdo_i = (tap_state == SHDR) ? tdi_o : ((tap_state == SHIR) ? ir_sr[0] : 1'b0);

  typedef struct packed {
    logic        err;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic tms_log  [0:255];
  logic tdi_log  [0:255];
  logic busy_log [0:255];

  task automatic step();
    @(posedge tck);
    #1;
  endtask

  task automatic issue_cmd(input logic [1:0] op, input logic [6:0] len, input logic [63:0] data,
                           input logic [63:0] exp_data, input logic exp_err);
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    cmd_valid = 1'b1;
    sb.push_back({exp_err, exp_data});
    step();
    cmd_valid = 1'b0;
  endtask

  // Returns the edge offset from acceptance at which rsp_valid was seen, or -1.
  task automatic wait_rsp(output int n);
    n = -1;
    for (int j = 0; j < 250 && n < 0; j++) begin
      tms_log[j]  = tms_o;
      tdi_log[j]  = tdi_o;
      busy_log[j] = busy;
      if (rsp_valid === 1'b1) n = j;
      else step();
    end
  endtask

  task automatic test_reset();
    logic [5:0] got;
    int bad;
    trst = 1'b1;
    step(); step(); step();
    checks++;
    if ({tms_o, tdi_o, busy, cmd_ready, rsp_valid, rsp_err} !== 6'b111000) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %b exp %b", {tms_o, tdi_o, busy, cmd_ready, rsp_valid, rsp_err}, 6'b111000);
    end
    checks++;
    if (rsp_data !== 64'd0) begin
      errors++;
      $display("[TB] FAIL reset_rsp_data got %h exp 0", rsp_data);
    end
    trst = 1'b0;
    bad = 0;
    for (int j = 0; j < 6; j++) begin
      step();
      got[j] = tms_o;
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) bad++;
    end
    checks++;
    if (got !== 6'b011111) begin
      errors++;
      $display("[TB] FAIL init_tlr_tms got %b exp %b", got, 6'b011111);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL init_tlr_handshake got %0d bad cycles exp 0", bad);
    end
    step();
    checks++;
    if ({cmd_ready, busy, tms_o, rsp_valid} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL init_done got %b exp %b", {cmd_ready, busy, tms_o, rsp_valid}, 4'b1000);
    end
    checks++;
    if (tap_state !== RTI) begin
      errors++;
      $display("[TB] FAIL init_tap_state got %0d exp %0d", tap_state, RTI);
    end
  endtask

  task automatic test_shift_ir();
    int n;
    exp_t e;
    logic [10:0] tms_got;
    logic [4:0] tdi_got;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ir_ready got %b exp 1", cmd_ready);
    end
    issue_cmd(OP_IR, 7'd5, 64'h15, 64'h01, 1'b0);
    wait_rsp(n);
    checks++;
    if (n !== 11) begin
      errors++;
      $display("[TB] FAIL ir_latency got %0d exp 11", n);
    end
    for (int j = 0; j < 11; j++) tms_got[j] = tms_log[j];
    for (int i = 0; i < 5; i++) tdi_got[i] = tdi_log[4 + i];
    checks++;
    if (tms_got !== 11'b01100000011) begin
      errors++;
      $display("[TB] FAIL ir_tms got %b exp %b", tms_got, 11'b01100000011);
    end
    checks++;
    if (tdi_got !== 5'b10101) begin
      errors++;
      $display("[TB] FAIL ir_tdi got %b exp %b", tdi_got, 5'b10101);
    end
    checks++;
    if ({busy_log[0], busy} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL ir_busy got %b exp 10", {busy_log[0], busy});
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL ir_rsp got response exp none queued");
    end else begin
      e = sb.pop_front();
      if ({rsp_err, rsp_data} !== e) begin
        errors++;
        $display("[TB] FAIL ir_rsp got err=%b data=%h exp err=%b data=%h", rsp_err, rsp_data, e.err, e.data);
      end
    end
    step();
    checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10 || tap_state !== RTI) begin
      errors++;
      $display("[TB] FAIL ir_after got ready/valid %b tap %0d exp 10 tap %0d", {cmd_ready, rsp_valid}, tap_state, RTI);
    end
  endtask

  task automatic test_shift_dr();
    int n;
    exp_t e;
    logic [6:0] tms_got;
    issue_cmd(OP_DR, 7'd64, 64'hDEADBEEF_0123ABCD, 64'hDEADBEEF_0123ABCD, 1'b0);
    wait_rsp(n);
    checks++;
    if (n !== 69) begin
      errors++;
      $display("[TB] FAIL dr_latency got %0d exp 69", n);
    end
    tms_got = {tms_log[0], tms_log[1], tms_log[2], tms_log[65], tms_log[66], tms_log[67], tms_log[68]};
    checks++;
    if (tms_got !== 7'b1000110) begin
      errors++;
      $display("[TB] FAIL dr_tms got %b exp %b", tms_got, 7'b1000110);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL dr_rsp got response exp none queued");
    end else begin
      e = sb.pop_front();
      if ({rsp_err, rsp_data} !== e) begin
        errors++;
        $display("[TB] FAIL dr_rsp got err=%b data=%h exp err=%b data=%h", rsp_err, rsp_data, e.err, e.data);
      end
    end
    step();
    checks++;
    if (cmd_ready !== 1'b1 || tap_state !== RTI) begin
      errors++;
      $display("[TB] FAIL dr_after got ready %b tap %0d exp 1 tap %0d", cmd_ready, tap_state, RTI);
    end
  endtask

  task automatic test_idle_and_reject();
    int n;
    int ones;
    exp_t e;
    logic [1:0]  ops  [4] = '{OP_IDLE, OP_IDLE, OP_DR, OP_IR};
    logic [6:0]  lens [4] = '{7'd10, 7'd0, 7'd0, 7'd65};
    int          lats [4] = '{10, 1, 1, 1};
    logic        errs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int t = 0; t < 4; t++) begin
      issue_cmd(ops[t], lens[t], 64'hFF, 64'd0, errs[t]);
      wait_rsp(n);
      checks++;
      if (n !== lats[t]) begin
        errors++;
        $display("[TB] FAIL idle_rej_latency case %0d got %0d exp %0d", t, n, lats[t]);
      end
      ones = 0;
      for (int j = 0; j <= lats[t] && j < 250; j++) if (tms_log[j] !== 1'b0) ones++;
      checks++;
      if (ones != 0) begin
        errors++;
        $display("[TB] FAIL idle_rej_tms case %0d got %0d high cycles exp 0", t, ones);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL idle_rej_rsp case %0d got response exp none queued", t);
      end else begin
        e = sb.pop_front();
        if ({rsp_err, rsp_data} !== e) begin
          errors++;
          $display("[TB] FAIL idle_rej_rsp case %0d got err=%b data=%h exp err=%b data=%h", t, rsp_err, rsp_data, e.err, e.data);
        end
      end
      step();
    end
    checks++;
    if (cmd_ready !== 1'b1 || tap_state !== RTI) begin
      errors++;
      $display("[TB] FAIL idle_rej_after got ready %b tap %0d exp 1 tap %0d", cmd_ready, tap_state, RTI);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    exp_t e;
    rsp_ready = 1'b0;
    issue_cmd(OP_DR, 7'd8, 64'hA5, 64'hA5, 1'b0);
    cmd_op    = OP_IR;
    cmd_len   = 7'd5;
    cmd_data  = 64'h1F;
    cmd_valid = 1'b1;
    wait_rsp(n);
    checks++;
    if (n !== 13) begin
      errors++;
      $display("[TB] FAIL bp_latency got %0d exp 13", n);
    end
    bad = 0;
    for (int j = 0; j < 20; j++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== 64'hA5 || cmd_ready !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL bp_stable got %0d unstable cycles exp 0", bad);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL bp_rsp1 got response exp none queued");
    end else begin
      e = sb.pop_front();
      if ({rsp_err, rsp_data} !== e) begin
        errors++;
        $display("[TB] FAIL bp_rsp1 got err=%b data=%h exp err=%b data=%h", rsp_err, rsp_data, e.err, e.data);
      end
    end
    rsp_ready = 1'b1;
    step();
    checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL bp_release got ready/valid %b exp 10", {cmd_ready, rsp_valid});
    end
    issue_cmd(OP_IR, 7'd5, 64'h1F, 64'h01, 1'b0);
    wait_rsp(n);
    checks++;
    if (n !== 11) begin
      errors++;
      $display("[TB] FAIL bp_second_latency got %0d exp 11", n);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL bp_rsp2 got response exp none queued");
    end else begin
      e = sb.pop_front();
      if ({rsp_err, rsp_data} !== e) begin
        errors++;
        $display("[TB] FAIL bp_rsp2 got err=%b data=%h exp err=%b data=%h", rsp_err, rsp_data, e.err, e.data);
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    int n;
    exp_t e;
    issue_cmd(OP_TLR, 7'd0, 64'd0, 64'd0, 1'b0);
    wait_rsp(n);
    checks++;
    if (n !== 6 || tap_state !== RTI) begin
      errors++;
      $display("[TB] FAIL b2b_tlr got latency %0d tap %0d exp 6 tap %0d", n, tap_state, RTI);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL b2b_rsp1 got response exp none queued");
    end else begin
      e = sb.pop_front();
      if ({rsp_err, rsp_data} !== e) begin
        errors++;
        $display("[TB] FAIL b2b_rsp1 got err=%b data=%h exp err=%b data=%h", rsp_err, rsp_data, e.err, e.data);
      end
    end
    step();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_gap got ready %b exp 1", cmd_ready);
    end
    issue_cmd(OP_DR, 7'd16, 64'hBEEF, 64'hBEEF, 1'b0);
    wait_rsp(n);
    checks++;
    if (n !== 21) begin
      errors++;
      $display("[TB] FAIL b2b_dr_latency got %0d exp 21", n);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL b2b_rsp2 got response exp none queued");
    end else begin
      e = sb.pop_front();
      if ({rsp_err, rsp_data} !== e) begin
        errors++;
        $display("[TB] FAIL b2b_rsp2 got err=%b data=%h exp err=%b data=%h", rsp_err, rsp_data, e.err, e.data);
      end
    end
    step();
  endtask

  task automatic test_reset_mid_shift();
    int n;
    int bad;
    exp_t e;
    logic [5:0] got;
    issue_cmd(OP_DR, 7'd32, 64'h12345670, 64'h12345670, 1'b0);
    for (int j = 0; j < 6; j++) step();
    checks++;
    if (tdi_o !== 1'b0 || tap_state !== SHDR) begin
      errors++;
      $display("[TB] FAIL mid_in_shift got tdi %b tap %0d exp tdi 0 tap %0d", tdi_o, tap_state, SHDR);
    end
    trst = 1'b1;
    step();
    sb.delete();
    checks++;
    if ({tms_o, busy, cmd_ready, rsp_valid} !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL mid_reset got %b exp %b", {tms_o, busy, cmd_ready, rsp_valid}, 4'b1100);
    end
    trst = 1'b0;
    bad = 0;
    for (int j = 0; j < 6; j++) begin
      step();
      got[j] = tms_o;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) bad++;
    end
    checks++;
    if (got !== 6'b011111 || bad != 0) begin
      errors++;
      $display("[TB] FAIL mid_init_tlr got tms %b bad %0d exp tms %b bad 0", got, bad, 6'b011111);
    end
    step();
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || tap_state !== RTI) begin
      errors++;
      $display("[TB] FAIL mid_recovered got ready %b valid %b tap %0d exp 1 0 tap %0d", cmd_ready, rsp_valid, tap_state, RTI);
    end
    issue_cmd(OP_DR, 7'd8, 64'h3C, 64'h3C, 1'b0);
    wait_rsp(n);
    checks++;
    if (n !== 13) begin
      errors++;
      $display("[TB] FAIL mid_next_latency got %0d exp 13", n);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL mid_next_rsp got response exp none queued");
    end else begin
      e = sb.pop_front();
      if ({rsp_err, rsp_data} !== e) begin
        errors++;
        $display("[TB] FAIL mid_next_rsp got err=%b data=%h exp err=%b data=%h", rsp_err, rsp_data, e.err, e.data);
      end
    end
    step();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_shift_ir();
    test_shift_dr();
    test_idle_and_reject();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
